// File: rtl/riscv_pkg.sv
// Shared core types: M-extension opcode encoding and the MUL/DIV sequencing states
// used by the pipeline controller.
package riscv_pkg;

  typedef enum logic [3:0] {
    M_NONE   = 4'd0,
    M_MUL    = 4'd1,
    M_MULH   = 4'd2,
    M_MULHSU = 4'd3,
    M_MULHU  = 4'd4,
    M_DIV    = 4'd5,
    M_DIVU   = 4'd6,
    M_REM    = 4'd7,
    M_REMU   = 4'd8
  } mul_op_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: prioritised stall/flush generation,
// MUL/DIV start/track/timeout, and a saturating stall-cycle counter.
module pipeline_ctrl
  import riscv_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       idex_rd_addr_i,
  input  logic             idex_mem_read_i,
  input  mul_op_t          idex_mul_op_i,
  input  logic             ex_redirect_i,
  input  logic             mem_busy_i,
  input  logic             trap_i,
  input  logic             md_done_i,
  output logic             md_start_o,
  output logic             md_abort_o,
  output logic             md_timeout_o,
  output logic             stall_pc_o,
  output logic             stall_ifid_o,
  output logic             flush_ifid_o,
  output logic             stall_idex_o,
  output logic             flush_idex_o,
  output logic             stall_exmem_o,
  output logic             flush_exmem_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam int TW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MD_TIMEOUT - 1);

  md_state_t        md_state_q;
  logic [TW-1:0]    md_cnt_q;
  logic [CNT_W-1:0] stall_cycles_q;

  logic load_use;
  logic md_busy;
  logic md_start;
  logic md_tmo_hit;
  logic md_stall;

  always_comb begin
    md_busy    = (md_state_q == MD_BUSY);
    load_use   = idex_mem_read_i && (idex_rd_addr_i != 5'd0) &&
                 ((id_uses_rs1_i && (id_rs1_addr_i == idex_rd_addr_i)) ||
                  (id_uses_rs2_i && (id_rs2_addr_i == idex_rd_addr_i)));
    md_start   = rst_n && !md_busy && (idex_mul_op_i != M_NONE) && !mem_busy_i && !trap_i;
    md_tmo_hit = md_busy && !md_done_i && (md_cnt_q == TMO_LAST);
    // The timeout cycle itself releases the pipeline; the result is discarded downstream.
    md_stall   = md_start || (md_busy && !md_done_i && !md_tmo_hit);
  end

  always_comb begin
    md_start_o    = 1'b0;
    md_abort_o    = 1'b0;
    md_timeout_o  = 1'b0;
    stall_pc_o    = 1'b0;
    stall_ifid_o  = 1'b0;
    flush_ifid_o  = 1'b0;
    stall_idex_o  = 1'b0;
    flush_idex_o  = 1'b0;
    stall_exmem_o = 1'b0;
    flush_exmem_o = 1'b0;
    if (!rst_n) begin
      md_start_o = 1'b0;
    end else if (trap_i) begin
      flush_ifid_o  = 1'b1;
      flush_idex_o  = 1'b1;
      flush_exmem_o = 1'b1;
      md_abort_o    = md_busy;
    end else if (mem_busy_i) begin
      stall_pc_o    = 1'b1;
      stall_ifid_o  = 1'b1;
      stall_idex_o  = 1'b1;
      stall_exmem_o = 1'b1;
    end else begin
      md_start_o   = md_start;
      md_abort_o   = md_tmo_hit;
      md_timeout_o = md_tmo_hit;
      if (md_stall) begin
        stall_pc_o    = 1'b1;
        stall_ifid_o  = 1'b1;
        stall_idex_o  = 1'b1;
        flush_exmem_o = 1'b1;
      end else if (ex_redirect_i) begin
        flush_ifid_o = 1'b1;
        flush_idex_o = 1'b1;
      end else if (load_use) begin
        stall_pc_o   = 1'b1;
        stall_ifid_o = 1'b1;
        flush_idex_o = 1'b1;
      end
    end
  end

  // A D-side stall freezes the sequencer completely, including the timeout count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_state_q <= MD_IDLE;
      md_cnt_q   <= '0;
    end else if (trap_i) begin
      md_state_q <= MD_IDLE;
      md_cnt_q   <= '0;
    end else if (!mem_busy_i) begin
      unique case (md_state_q)
        MD_IDLE: begin
          if (md_start) begin
            md_state_q <= MD_BUSY;
            md_cnt_q   <= '0;
          end
        end
        MD_BUSY: begin
          if (md_done_i || md_tmo_hit) begin
            md_state_q <= MD_IDLE;
            md_cnt_q   <= '0;
          end else begin
            md_cnt_q <= md_cnt_q + TW'(1);
          end
        end
        default: begin
          md_state_q <= MD_IDLE;
          md_cnt_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else if (stall_pc_o && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end
  end

  assign stall_cycles_o = stall_cycles_q;

endmodule
